// File: rtl/axis_rd_checker_pkg.sv
// axis_rd_checker_pkg: shared state encoding and constants for the AXIS read-data checker.
package axis_rd_checker_pkg;
   typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
   localparam int LANE_W = 32;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/axis_rd_checker_pat.sv
// axis_rd_checker_pat: expected word-counter pattern for a beat index plus a registered compare stage.
module axis_rd_checker_pat
   import axis_rd_checker_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  hs_i,
   input  logic [31:0]           idx_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  chk_o,
   output logic                  mis_o,
   output logic [31:0]           idx_o
);
   localparam int N = DATA_WIDTH / LANE_W;
   logic [DATA_WIDTH-1:0] exp_w;
   logic                  chk_q, mis_q;
   logic [31:0]           idx_q;
   for (genvar i = 0; i < N; i++) begin : g_lane
      assign exp_w[i*LANE_W +: LANE_W] = idx_i * 32'(N) + 32'(i);
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         chk_q <= 1'b0;
         mis_q <= 1'b0;
         idx_q <= '0;
      end else begin
         chk_q <= hs_i;
         mis_q <= hs_i && (data_i != exp_w);
         idx_q <= idx_i;
      end
   end
   assign chk_o = chk_q;
   assign mis_o = mis_q;
   assign idx_o = idx_q;
endmodule

// File: rtl/axis_rd_checker.sv
// axis_rd_checker: AXIS sink that checks read beats against the word-counter pattern and times the run.
// Optional upstream back-pressure exerciser: define AXIS_RD_CHECKER_THROTTLE_EN.
module axis_rd_checker
   import axis_rd_checker_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   input  logic                    START_REG,
   input  logic [31:0]             LENGTH_REG,
   output logic                    BUSY_REG,
   output logic                    DONE_REG,
   output logic [31:0]             BEATS_REG,
   output logic [31:0]             ERRORS_REG,
   output logic [31:0]             FIRST_ERR_REG,
   output logic [31:0]             CYCLES_REG
);
   state_t      state_q;
   logic        start_q, pend_q, done_q, thr_w, hs_w, chk_w, mis_w, unused_w;
   logic [31:0] len_q, beats_q, errors_q, first_q, cycles_q, idx_w;
`ifdef AXIS_RD_CHECKER_THROTTLE_EN
   logic [15:0] lfsr_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) lfsr_q <= LFSR_SEED;
      else lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end
   assign thr_w = lfsr_q[1:0] != 2'b00;
`else
   assign thr_w = 1'b1;
`endif
   assign unused_w      = ^{s_axis_tstrb, s_axis_tlast};
   assign BUSY_REG      = state_q == ARMED || state_q == RUN;
   assign s_axis_tready = BUSY_REG && thr_w;
   assign hs_w          = s_axis_tvalid && s_axis_tready;
   axis_rd_checker_pat #(.DATA_WIDTH(DATA_WIDTH)) u_pat (
      .clk(clk), .rstn(rstn), .hs_i(hs_w), .idx_i(beats_q), .data_i(s_axis_tdata),
      .chk_o(chk_w), .mis_o(mis_w), .idx_o(idx_w)
   );
   // DONE_REG trails the final handshake by two edges so the last compare has landed.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         start_q  <= 1'b0;
         pend_q   <= 1'b0;
         done_q   <= 1'b0;
         len_q    <= '0;
         beats_q  <= '0;
         errors_q <= '0;
         first_q  <= '1;
         cycles_q <= '0;
      end else begin
         start_q <= START_REG;
         pend_q  <= 1'b0;
         done_q  <= done_q || pend_q;
         if (chk_w && mis_w) begin
            if (errors_q != '1) errors_q <= errors_q + 1;
            if (first_q == '1) first_q <= idx_w;
         end
         case (state_q)
            IDLE, DONE: if (START_REG && !start_q) begin
               len_q    <= LENGTH_REG;
               beats_q  <= '0;
               errors_q <= '0;
               cycles_q <= '0;
               first_q  <= '1;
               done_q   <= 1'b0;
               pend_q   <= LENGTH_REG == 0;
               state_q  <= LENGTH_REG == 0 ? DONE : ARMED;
            end
            ARMED: if (hs_w) begin
               beats_q  <= 32'd1;
               cycles_q <= 32'd1;
               pend_q   <= len_q == 1;
               state_q  <= len_q == 1 ? DONE : RUN;
            end
            RUN: begin
               if (cycles_q != '1) cycles_q <= cycles_q + 1;
               if (hs_w) begin
                  beats_q <= beats_q + 1;
                  if (beats_q == len_q - 1) begin
                     pend_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign DONE_REG      = done_q;
   assign BEATS_REG     = beats_q;
   assign ERRORS_REG    = errors_q;
   assign FIRST_ERR_REG = first_q;
   assign CYCLES_REG    = cycles_q;
endmodule

// File: tb/tb_axis_rd_checker.sv
// tb_axis_rd_checker: directed runs with a result scoreboard popped on each DONE_REG rising edge.
module tb_axis_rd_checker;
   localparam int DW = 64;
   typedef struct {
      logic [31:0] beats, errs, first, cyc;
   } exp_t;
   logic          clk = 1'b0, rstn = 1'b0;
   logic          tvalid = 1'b0, tready, tlast = 1'b0, start = 1'b0;
   logic [DW-1:0] tdata = '0;
   logic [DW/8-1:0] tstrb = '1;
   logic [31:0]   length = '0;
   logic          busy, done;
   logic [31:0]   beats, errs, first, cyc;
   logic          done_prev = 1'b0;
   exp_t          sb[$];
   int            errors = 0, checks = 0;
   always #5 clk = ~clk;
   axis_rd_checker #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rstn(rstn), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
      .s_axis_tstrb(tstrb), .s_axis_tlast(tlast), .s_axis_tready(tready),
      .START_REG(start), .LENGTH_REG(length), .BUSY_REG(busy), .DONE_REG(done),
      .BEATS_REG(beats), .ERRORS_REG(errs), .FIRST_ERR_REG(first), .CYCLES_REG(cyc)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [DW-1:0] pat(input int k);
      logic [31:0] lo, hi;
      lo = 32'(k * 2);
      hi = 32'(k * 2 + 1);
      return {hi, lo};
   endfunction
   always @(negedge clk) begin
      if (done && !done_prev) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: DONE rose with no expected result queued");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("beats", beats, e.beats);
            chk("errors", errs, e.errs);
            chk("first_err", first, e.first);
            chk("cycles", cyc, e.cyc);
         end
      end
      done_prev = done;
   end
   task automatic start_run(input logic [31:0] len);
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      length = len;
   endtask
   task automatic send_beats(input int len, input int corrupt, input int gap_at, input int gap_n);
      int k = 0, g = 0, n = 0;
      logic hs;
      while (k < len && n < 300) begin
         @(negedge clk);
         n++;
         if (k == gap_at && g < gap_n) begin
            tvalid = 1'b0;
            g++;
         end else begin
            tvalid = 1'b1;
            tdata = pat(k);
            if (k == corrupt) tdata[63:32] = tdata[63:32] + 1;
         end
         hs = tvalid && tready;
         @(posedge clk);
         if (hs) k++;
      end
      @(negedge clk) tvalid = 1'b0;
      chk("beats_sent", k, len);
   endtask
   task automatic wait_done();
      int n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", {31'd0, done}, 1);
   endtask
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tready"}, {31'd0, tready}, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
      chk({tag, "_done"}, {31'd0, done}, 0);
      chk({tag, "_beats"}, beats, 0);
      chk({tag, "_errors"}, errs, 0);
      chk({tag, "_cycles"}, cyc, 0);
      chk({tag, "_first"}, first, 32'hFFFF_FFFF);
   endtask
   initial begin
      #12 chk_reset_vals("rst");
      @(negedge clk) rstn = 1'b1;
      sb.push_back('{32'd16, 32'd0, 32'hFFFF_FFFF, 32'd16});
      start_run(16);
      send_beats(16, -1, -1, 0);
      wait_done();
      sb.push_back('{32'd16, 32'd1, 32'd5, 32'd16});
      start_run(16);
      send_beats(16, 5, -1, 0);
      wait_done();
      sb.push_back('{32'd8, 32'd0, 32'hFFFF_FFFF, 32'd11});
      start_run(8);
      send_beats(8, -1, 4, 3);
      wait_done();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tvalid = 1'b1;
         tdata = pat(8 + i);
         #1;
         chk("post_tready", {31'd0, tready}, 0);
         chk("post_beats", beats, 8);
         chk("post_busy", {31'd0, busy}, 0);
      end
      @(negedge clk) tvalid = 1'b0;
      chk("post_done", {31'd0, done}, 1);
      sb.push_back('{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0});
      start_run(0);
      @(negedge clk);
      chk("len0_done_early", {31'd0, done}, 0);
      chk("len0_tready1", {31'd0, tready}, 0);
      chk("len0_busy", {31'd0, busy}, 0);
      @(negedge clk);
      chk("len0_done", {31'd0, done}, 1);
      chk("len0_tready2", {31'd0, tready}, 0);
      start_run(16);
      send_beats(7, -1, -1, 0);
      chk("mid_busy", {31'd0, busy}, 1);
      chk("mid_beats", beats, 7);
      start = 1'b0;
      rstn = 1'b0;
      #1 chk_reset_vals("midrst");
      @(negedge clk) rstn = 1'b1;
      sb.push_back('{32'd4, 32'd0, 32'hFFFF_FFFF, 32'd4});
      start_run(4);
      send_beats(4, -1, -1, 0);
      wait_done();
      @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
